// File: rtl/bus_dir_if.sv
// ----------------------------------------------------------------------------
// bus_dir_if
//
// Purpose: bundles the request/grant/direction signals between the two link
// sides (A and B) and the bus direction controller.
//
// Signals:
//   req_a  - A wants to drive A->B (level, held for the whole transfer)
//   req_b  - B wants to drive B->A (level, held for the whole transfer)
//   en     - buffer direction: 1 = A drives B, 0 = B drives A
//   gnt_a  - A may drive
//   gnt_b  - B may drive
//   busy   - high while the link is in a dead turnaround
//   state  - controller FSM state, for debug/observation only
//            (0 = IDLE, 1 = GNT_A, 2 = GNT_B, 3 = TURN)
//
// Modports:
//   master - the requesting sides: drive req_*, observe everything else
//   slave  - the controller: observes req_*, drives everything else
//
// Handshake: req_X is a level request that stays high for the whole
// transfer. gnt_X rises when side X may drive and stays high while req_X
// stays high. Side X drops req_X to release the link; gnt_X falls after the
// next rising edge. A side must not drive while its gnt is low.
// ----------------------------------------------------------------------------
interface bus_dir_if;
    logic       req_a;
    logic       req_b;
    logic       en;
    logic       gnt_a;
    logic       gnt_b;
    logic       busy;
    logic [1:0] state;

    modport master (
        output req_a,
        output req_b,
        input  en,
        input  gnt_a,
        input  gnt_b,
        input  busy,
        input  state
    );

    modport slave (
        input  req_a,
        input  req_b,
        output en,
        output gnt_a,
        output gnt_b,
        output busy,
        output state
    );
endinterface

// File: rtl/bus_dir_ctrl.sv
// ----------------------------------------------------------------------------
// bus_dir_ctrl
//
// Purpose: direction controller for the half-duplex bidirectional buffer.
// Arbitrates between sides A and B, produces the buffer direction select
// (en) and inserts TURN dead cycles whenever the direction reverses, so no
// side drives during a reversal. Simultaneous requests alternate, favouring
// the side not served most recently.
//
// Parameters:
//   TURN     - turnaround length in cycles on a reversal (1..15)
//   MAXBURST - granted cycles before a forced handover when the other side
//              is waiting (2..255); only used with the burst limit
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - bus_dir_if.slave: req_a/req_b in; en, gnt_a, gnt_b, busy and
//            debug state out (all outputs registered)
//
// Optional feature macro:
//   BUS_DIR_BURST_LIMIT_EN - when defined, an active grant is cut after
//   MAXBURST cycles if the other side is requesting, and the link turns
//   straight toward the other side. When undefined a grant lasts until its
//   request drops.
// ----------------------------------------------------------------------------
module bus_dir_ctrl #(
    parameter int unsigned TURN     = 2,
    parameter int unsigned MAXBURST = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    bus_dir_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2,
        ST_TURN  = 2'd3
    } state_t;

    // The turnaround counter is loaded with TURN-1 and the grant issues on
    // the edge that finds it at zero, giving exactly TURN busy cycles.
    localparam logic [3:0] TURN_LOAD = 4'(TURN - 1);

    // Parameter legality, checked at elaboration.
    if (TURN < 1 || TURN > 15) begin : g_turn_range
        $error("bus_dir_ctrl: TURN must be in 1..15");
    end
    if (MAXBURST < 2 || MAXBURST > 255) begin : g_maxburst_range
        $error("bus_dir_ctrl: MAXBURST must be in 2..255");
    end

    state_t     state;
    logic       en_q;
    logic       gnt_a_q;
    logic       gnt_b_q;
    logic       busy_q;
    logic       last_a;     // 1: A was served most recently, 0: B
    logic       pend_a;     // turnaround target: 1 = A, 0 = B
    logic [3:0] turn_cnt;

    // ------------------------------------------------------------------
    // Target selection in IDLE: a lone request wins; with both high the
    // side that was not served last wins.
    // ------------------------------------------------------------------
    logic any_req;
    logic tgt_a;

    always_comb begin
        any_req = bus.req_a | bus.req_b;
        if (bus.req_a && bus.req_b) begin
            tgt_a = ~last_a;
        end else begin
            tgt_a = bus.req_a;
        end
    end

    // Request of the side currently holding the grant.
    logic own_req;

    always_comb begin
        own_req = (state == ST_GNT_A) ? bus.req_a : bus.req_b;
    end

`ifdef BUS_DIR_BURST_LIMIT_EN
    // burst_cnt counts completed grant cycles. On the edge that closes the
    // MAXBURST-th granted cycle it sits at MAXBURST-1; it saturates there
    // so a grant with nobody waiting simply continues.
    localparam logic [7:0] BURST_LAST = 8'(MAXBURST - 1);

    logic [7:0] burst_cnt;
    logic       other_req;
    logic       burst_hit;

    always_comb begin
        other_req = (state == ST_GNT_A) ? bus.req_b : bus.req_a;
        burst_hit = (burst_cnt == BURST_LAST) && other_req;
    end
`endif

    // ------------------------------------------------------------------
    // FSM with registered outputs. en only moves on entry to ST_TURN, and
    // every path into ST_TURN clears both grants in the same edge, so en
    // never changes under an active grant.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            en_q      <= 1'b1;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            busy_q    <= 1'b0;
            last_a    <= 1'b0;
            pend_a    <= 1'b0;
            turn_cnt  <= 4'd0;
`ifdef BUS_DIR_BURST_LIMIT_EN
            burst_cnt <= 8'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        if (tgt_a == en_q) begin
                            // Link already points the right way.
                            state     <= tgt_a ? ST_GNT_A : ST_GNT_B;
                            gnt_a_q   <= tgt_a;
                            gnt_b_q   <= ~tgt_a;
                            last_a    <= tgt_a;
`ifdef BUS_DIR_BURST_LIMIT_EN
                            burst_cnt <= 8'd0;
`endif
                        end else begin
                            // Reverse: flip the buffer now, grant later.
                            state    <= ST_TURN;
                            en_q     <= tgt_a;
                            busy_q   <= 1'b1;
                            turn_cnt <= TURN_LOAD;
                            pend_a   <= tgt_a;
                        end
                    end
                end

                ST_TURN: begin
                    // Requests are not looked at here; the latched target
                    // is granted even if it has since let go.
                    if (turn_cnt == 4'd0) begin
                        state     <= pend_a ? ST_GNT_A : ST_GNT_B;
                        gnt_a_q   <= pend_a;
                        gnt_b_q   <= ~pend_a;
                        busy_q    <= 1'b0;
                        last_a    <= pend_a;
`ifdef BUS_DIR_BURST_LIMIT_EN
                        burst_cnt <= 8'd0;
`endif
                    end else begin
                        turn_cnt <= turn_cnt - 4'd1;
                    end
                end

                ST_GNT_A, ST_GNT_B: begin
                    if (!own_req) begin
                        gnt_a_q <= 1'b0;
                        gnt_b_q <= 1'b0;
                        state   <= ST_IDLE;
                    end
`ifdef BUS_DIR_BURST_LIMIT_EN
                    else if (burst_hit) begin
                        // Forced handover: skip IDLE and turn straight
                        // toward the waiting side.
                        gnt_a_q  <= 1'b0;
                        gnt_b_q  <= 1'b0;
                        state    <= ST_TURN;
                        en_q     <= (state == ST_GNT_B);
                        busy_q   <= 1'b1;
                        turn_cnt <= TURN_LOAD;
                        pend_a   <= (state == ST_GNT_B);
                        last_a   <= (state == ST_GNT_A);
                    end else if (burst_cnt != BURST_LAST) begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
`endif
                end

                default: begin
                    state   <= ST_IDLE;
                    gnt_a_q <= 1'b0;
                    gnt_b_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.en    = en_q;
    assign bus.gnt_a = gnt_a_q;
    assign bus.gnt_b = gnt_b_q;
    assign bus.busy  = busy_q;
    assign bus.state = state;

endmodule

// File: tb/tb_bus_dir_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bus_dir_ctrl
//
// Bench for bus_dir_ctrl with TURN=2, MAXBURST=4. A reference model of the
// arbitration rules predicts {en, gnt_a, gnt_b, busy} after every rising
// edge and a compare process checks the DUT at each falling edge; directed
// scenarios add hand-computed literal checks.
// ----------------------------------------------------------------------------
module tb_bus_dir_ctrl;

    localparam int TURN_P     = 2;
    localparam int MAXBURST_P = 4;
`ifdef BUS_DIR_BURST_LIMIT_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bus_dir_if bus ();

    bus_dir_ctrl #(
        .TURN     (TURN_P),
        .MAXBURST (MAXBURST_P)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "bench timeout");
    end

    // ------------------------------------------------------------------
    // Reference model: owner of the link (0 none, 1 A, 2 B), remaining
    // dead cycles, pending side, last served side, cycles held so far.
    // ------------------------------------------------------------------
    int m_owner;
    int m_turn_left;
    int m_pending;
    int m_last;
    int m_held;
    bit m_dir_a;

    logic [3:0] exp_q[$];

    task automatic m_reset();
        m_owner     = 0;
        m_turn_left = 0;
        m_pending   = 0;
        m_last      = 2;
        m_held      = 0;
        m_dir_a     = 1'b1;
    endtask

    function automatic logic [3:0] m_vec();
        return {m_dir_a, (m_owner == 1), (m_owner == 2), (m_turn_left > 0)};
    endfunction

    task automatic m_step(input bit ra, input bit rb);
        bit mine;
        bit other;
        int tgt;
        if (m_turn_left > 0) begin
            m_turn_left--;
            if (m_turn_left == 0) begin
                m_owner = m_pending;
                m_last  = m_pending;
                m_held  = 1;
            end
        end else if (m_owner != 0) begin
            mine  = (m_owner == 1) ? ra : rb;
            other = (m_owner == 1) ? rb : ra;
            if (!mine) begin
                m_owner = 0;
            end else if (BURST_ON && m_held >= MAXBURST_P && other) begin
                m_last      = m_owner;
                m_pending   = 3 - m_owner;
                m_owner     = 0;
                m_dir_a     = !m_dir_a;
                m_turn_left = TURN_P;
            end else begin
                m_held++;
            end
        end else if (ra || rb) begin
            tgt = (ra && rb) ? (3 - m_last) : (ra ? 1 : 2);
            if ((tgt == 1) == m_dir_a) begin
                m_owner = tgt;
                m_last  = tgt;
                m_held  = 1;
            end else begin
                m_dir_a     = (tgt == 1);
                m_pending   = tgt;
                m_turn_left = TURN_P;
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_reset();
                exp_q.delete();
                exp_q.push_back(m_vec());
            end else begin
                m_step(bus.req_a, bus.req_b);
                exp_q.push_back(m_vec());
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard compare, away from the active edge
    // ------------------------------------------------------------------
    initial begin
        logic [3:0] exp_v;
        logic [3:0] got_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                got_v = {bus.en, bus.gnt_a, bus.gnt_b, bus.busy};
                n_checks++;
                if (got_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL model_cmp t=%0t en/gnt_a/gnt_b/busy got=%b want=%b state=%0d",
                             $time, got_v, exp_v, bus.state);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks and literal checks
    // ------------------------------------------------------------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check_out(input string name, input logic [3:0] want);
        logic [3:0] got_v;
        got_v = {bus.en, bus.gnt_a, bus.gnt_b, bus.busy};
        n_checks++;
        if (got_v !== want) begin
            n_fail++;
            $display("FAIL %s en/gnt_a/gnt_b/busy got=%b want=%b", name, got_v, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic set_req(input bit ra, input bit rb);
        bus.req_a = ra;
        bus.req_b = rb;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        set_req(1'b0, 1'b0);
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    // Directed request pattern {req_a, req_b}, one entry per cycle.
    localparam int NPAT = 20;
    logic [1:0] pat [NPAT] = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b11,
                               2'b11, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00,
                               2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11,
                               2'b11, 2'b00};

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int cnt_a;
        int cnt_busy;
        int first_b;

        rst_n = 1'b0;
        set_req(1'b0, 1'b0);
        repeat (3) cyc();
        check_out("reset_state", 4'b1000);
        rst_n = 1'b1;

        // Reversal from reset: en flips after edge 1, grant after edge 3.
        set_req(1'b0, 1'b1);
        cyc(); check_out("rev_edge1", 4'b0001);
        cyc(); check_out("rev_edge2", 4'b0001);
        cyc(); check_out("rev_edge3_gnt_b", 4'b0010);
        set_req(1'b0, 1'b0);
        cyc(); check_out("rev_release", 4'b0000);

        // Reset mid-GNT_B.
        set_req(1'b0, 1'b1);
        cyc(); check_out("pre_rst_gnt_b", 4'b0010);
        #2 rst_n = 1'b0;
        #1 check_out("rst_mid_gnt_b", 4'b1000);
        cyc();
        rst_n = 1'b1;

        // Reset mid-TURN (req_b still high, en back to 1 after reset).
        cyc(); check_out("pre_rst_turn", 4'b0001);
        #2 rst_n = 1'b0;
        #1 check_out("rst_mid_turn", 4'b1000);
        cyc();
        rst_n = 1'b1;
        set_req(1'b1, 1'b0);
        cyc(); check_out("post_rst_gnt_a", 4'b1100);
        set_req(1'b0, 1'b0);
        cyc();

        // Simultaneous requests after reset: A first, then B, then A.
        reset_dut();
        set_req(1'b1, 1'b1);
        cyc(); check_out("sim_a_first", 4'b1100);
        cyc(); check_out("sim_a_hold", 4'b1100);
        set_req(1'b0, 1'b1);
        cyc(); check_out("sim_a_release", 4'b1000);
        cyc(); check_out("sim_turn1", 4'b0001);
        cyc(); check_out("sim_turn2", 4'b0001);
        cyc(); check_out("sim_gnt_b", 4'b0010);
        set_req(1'b1, 1'b1);
        cyc(); check_out("sim_b_hold", 4'b0010);
        set_req(1'b1, 1'b0);
        cyc(); check_out("sim_b_release", 4'b0000);
        cyc(); check_out("sim_turn_a1", 4'b1001);
        cyc(); check_out("sim_turn_a2", 4'b1001);
        cyc(); check_out("sim_gnt_a_again", 4'b1100);
        set_req(1'b0, 1'b0);
        cyc();

        // Same-direction repeat: 3-cycle pulses with 1 idle cycle.
        for (int p = 0; p < 3; p++) begin
            set_req(1'b1, 1'b0);
            cyc(); check_out("same_dir_gnt", 4'b1100);
            cyc();
            cyc(); check_out("same_dir_hold", 4'b1100);
            set_req(1'b0, 1'b0);
            cyc(); check_out("same_dir_release", 4'b1000);
        end

        // Burst scenario: req_a held, req_b raised, req_a dropped at 20.
        set_req(1'b1, 1'b0);
        cyc(); check_out("burst_gnt_a", 4'b1100);
        cnt_a    = 1;
        cnt_busy = 0;
        first_b  = -1;
        set_req(1'b1, 1'b1);
        for (int i = 1; i < 25; i++) begin
            if (i == 20) bus.req_a = 1'b0;
            cyc();
            if (first_b < 0) begin
                if (bus.gnt_a) cnt_a++;
                if (bus.busy) cnt_busy++;
                if (bus.gnt_b) first_b = i;
            end
        end
        check_int("burst_gnt_a_cycles", cnt_a, BURST_ON ? 4 : 20);
        check_int("burst_busy_cycles", cnt_busy, 2);
        check_int("burst_first_gnt_b", first_b, BURST_ON ? 6 : 23);
        set_req(1'b0, 1'b0);
        repeat (8) cyc();

        // Target drops its request during TURN: grant still issues, then
        // releases one cycle later.
        reset_dut();
        set_req(1'b0, 1'b1);
        cyc(); check_out("drop_turn1", 4'b0001);
        set_req(1'b0, 1'b0);
        cyc(); check_out("drop_turn2", 4'b0001);
        cyc(); check_out("drop_late_gnt_b", 4'b0010);
        cyc(); check_out("drop_late_release", 4'b0000);

        // Directed pattern table, checked by the model only.
        for (int i = 0; i < NPAT; i++) begin
            set_req(pat[i][1], pat[i][0]);
            cyc();
        end
        set_req(1'b0, 1'b0);
        repeat (8) cyc();

        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
